// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer execute unit.
//   - ALU_* control codes (3 bits), also used by the ALU control decoder
//   - aluState_t: execute-unit FSM state encoding
//   - isShiftOp(): true for the three shift control codes
// Build option consumed elsewhere: ALU_BARREL_SHIFT_EN (single-cycle shifts).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } aluState_t;

    function automatic logic isShiftOp(input logic [2:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
// Serial one-bit-per-cycle shifter used by alu_exec_unit for SLL/SRL/SRA.
// Only present when ALU_BARREL_SHIFT_EN is NOT defined.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : load i_value / i_shamt / i_op (parent only starts when shamt > 0)
//   i_op         : ALU control code of the shift
//   i_value      : operand to shift
//   i_shamt      : shift amount
//   o_done       : the shift taking place this cycle is the final one
//   o_next       : working register shifted by one more bit
// ---------------------------------------------------------------------------
`ifndef ALU_BARREL_SHIFT_EN
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [2:0]               i_op,
    input  logic [XLEN-1:0]          i_value,
    input  logic [$clog2(XLEN)-1:0]  i_shamt,
    output logic                     o_done,
    output logic [XLEN-1:0]          o_next
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] COUNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] r_work;
    logic [SHW-1:0]  r_count;
    logic            r_left;
    logic            r_arith;
    logic            w_fill;

    // One-bit shift of the working register; SRA replicates the sign bit,
    // SRL brings in zero.
    always_comb begin
        w_fill = r_arith ? r_work[XLEN-1] : 1'b0;
        o_next = r_left ? {r_work[XLEN-2:0], 1'b0} : {w_fill, r_work[XLEN-1:1]};
        o_done = (r_count == COUNT_ONE);
    end

    // The counter holds the number of shifts still to perform; it rests at
    // zero once the final shift has been handed to the parent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_start) begin
            r_work  <= i_value;
            r_count <= i_shamt;
            r_left  <= (i_op == ALU_SLL);
            r_arith <= (i_op == ALU_SRA);
        end else if (r_count != '0) begin
            r_work  <= o_next;
            r_count <= r_count - COUNT_ONE;
        end
    end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle integer execute unit with valid/ready on input and output.
// Build option: ALU_BARREL_SHIFT_EN -- when defined, shifts complete in one
// cycle via a barrel shifter and the serial shifter is not instantiated.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : operation handshake
//   alu_control, op_a, op_b  : operation code and operands (accept cycle only)
//   out_valid / out_ready    : result handshake
//   result, zero, negative, carry : registered result and flags
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            carry
);

    localparam int SHW = $clog2(XLEN);

    aluState_t       r_state;
    aluState_t       w_nextState;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_negative;
    logic            r_carry;

    logic            w_accept;
    logic            w_isShift;
    logic            w_startShift;
    logic            w_shiftDone;
    logic [XLEN-1:0] w_shiftNext;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_immResult;
    logic            w_immCarry;

    assign w_shamt   = op_b[SHW-1:0];
    assign w_isShift = isShiftOp(alu_control);
    assign w_accept  = in_valid && in_ready;

    // The carry bit of op_a + ~op_b + 1 is the no-borrow flag for SUB.
    assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign w_diff = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};

`ifdef ALU_BARREL_SHIFT_EN
    assign w_startShift = 1'b0;
    assign w_shiftDone  = 1'b1;
    assign w_shiftNext  = '0;
`else
    // Only non-zero shift amounts go through the serial shifter; a zero
    // amount falls through the single-cycle path with result = op_a.
    assign w_startShift = w_accept && w_isShift && (w_shamt != '0);

    alu_shift_iter #(
        .XLEN (XLEN)
    ) u_shiftIter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_startShift),
        .i_op    (alu_control),
        .i_value (op_a),
        .i_shamt (w_shamt),
        .o_done  (w_shiftDone),
        .o_next  (w_shiftNext)
    );
`endif

    // Single-cycle result for the accept cycle. Shift codes default to op_a,
    // which is the correct result for a zero shift amount.
    always_comb begin
        w_immResult = op_a;
        w_immCarry  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                w_immResult = w_sum[XLEN-1:0];
                w_immCarry  = w_sum[XLEN];
            end
            ALU_SUB: begin
                w_immResult = w_diff[XLEN-1:0];
                w_immCarry  = w_diff[XLEN];
            end
            ALU_AND: w_immResult = op_a & op_b;
            ALU_OR:  w_immResult = op_a | op_b;
            ALU_XOR: w_immResult = op_a ^ op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: w_immResult = op_a << w_shamt;
            ALU_SRL: w_immResult = op_a >> w_shamt;
            ALU_SRA: w_immResult = $unsigned($signed(op_a) >>> w_shamt);
`endif
            default: w_immResult = op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // DONE behaves like IDLE whenever the consumer takes the result, so a new
    // operation can be accepted in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_nextState = w_startShift ? ST_SHIFT : ST_DONE;
                end else if ((r_state == ST_DONE) && out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_shiftDone) begin
                    w_nextState = ST_DONE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        out_valid = (r_state == ST_DONE);
    end

    // Carry is captured at accept time (zero for shifts); zero/negative are
    // taken from whichever value becomes the final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
        end else if (w_accept) begin
            r_carry <= w_immCarry;
            if (!w_startShift) begin
                r_result   <= w_immResult;
                r_zero     <= (w_immResult == '0);
                r_negative <= w_immResult[XLEN-1];
            end
        end else if ((r_state == ST_SHIFT) && w_shiftDone) begin
            r_result   <= w_shiftNext;
            r_zero     <= (w_shiftNext == '0);
            r_negative <= w_shiftNext[XLEN-1];
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign negative = r_negative;
    assign carry    = r_carry;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: directed cases, backpressure,
// back-to-back throughput, reset during a shift, and randomized operations
// compared against an arithmetic reference model.
// Honours ALU_BARREL_SHIFT_EN for expected shift latency.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [2:0]  aluControl;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        outReady;
    logic [31:0] resultBus;
    logic        zeroFlag;
    logic        negFlag;
    logic        carryFlag;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(
        .XLEN (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .alu_control (aluControl),
        .op_a        (opA),
        .op_b        (opB),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .result      (resultBus),
        .zero        (zeroFlag),
        .negative    (negFlag),
        .carry       (carryFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the operation definitions.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] res,
                                     output logic cy);
        logic [63:0] wide;
        int unsigned sh;
        sh   = b % 32;
        wide = {32'b0, a} + {32'b0, b};
        cy   = 1'b0;
        res  = 32'h0;
        case (op)
            ALU_ADD: begin res = wide[31:0]; cy = wide[32]; end
            ALU_SUB: begin res = a - b;      cy = (a >= b); end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLL: res = a << sh;
            ALU_SRL: res = a >> sh;
            default: res = $unsigned($signed(a) >>> sh);
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return (op == 3'b111) ? 1 : 1;
`else
        if (op >= ALU_SLL && (b % 32) != 0) return 1 + int'(b % 32);
        return 1;
`endif
    endfunction

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int lat);
        @(negedge clk);
        aluControl = op;
        opA        = a;
        opB        = b;
        inValid    = 1'b1;
        checkEq({tag, ".in_ready"}, 32'(inReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (outValid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int lat);
        logic [31:0] er;
        logic        ec;
        refModel(op, a, b, er, ec);
        checkEq({tag, ".out_valid"}, 32'(outValid), 32'd1);
        checkEq({tag, ".result"}, resultBus, er);
        checkEq({tag, ".zero"}, 32'(zeroFlag), 32'(er == 32'd0));
        checkEq({tag, ".negative"}, 32'(negFlag), 32'(er[31]));
        checkEq({tag, ".carry"}, 32'(carryFlag), 32'(ec));
        checkEq({tag, ".latency"}, lat, expLatency(op, b));
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int lat;
        applyStimulus(tag, op, a, b, lat);
        checkOutput(tag, op, a, b, lat);
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [2:0]  prevOp;
        logic [31:0] prevA;
        logic [31:0] prevB;
        logic [31:0] er;
        logic        ec;
        int          sawValid;

        rstN       = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b1;
        aluControl = 3'b000;
        opA        = 32'h0;
        opB        = 32'h0;
        repeat (2) @(negedge clk);

        checkEq("reset.out_valid", 32'(outValid), 32'd0);
        checkEq("reset.result", resultBus, 32'd0);
        checkEq("reset.zero", 32'(zeroFlag), 32'd0);
        checkEq("reset.negative", 32'(negFlag), 32'd0);
        checkEq("reset.carry", 32'(carryFlag), 32'd0);
        checkEq("reset.in_ready", 32'(inReady), 32'd1);
        rstN = 1'b1;

        // Directed cases from the operation definitions
        runOp("add_5_7", ALU_ADD, 32'd5, 32'd7);
        checkEq("add_5_7.literal", resultBus, 32'd12);
        runOp("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        checkEq("add_wrap.carry_literal", 32'(carryFlag), 32'd1);
        runOp("sub_3_5", ALU_SUB, 32'd3, 32'd5);
        checkEq("sub_3_5.literal", resultBus, 32'hFFFF_FFFE);
        runOp("sub_5_5", ALU_SUB, 32'd5, 32'd5);
        runOp("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        runOp("or", ALU_OR, 32'hF000_0001, 32'h0000_0F00);
        runOp("sra_4", ALU_SRA, 32'h8000_0000, 32'd4);
        checkEq("sra_4.literal", resultBus, 32'hF800_0000);
        runOp("srl_4", ALU_SRL, 32'h8000_0000, 32'd4);
        checkEq("srl_4.literal", resultBus, 32'h0800_0000);
        runOp("sll_31", ALU_SLL, 32'd1, 32'd31);
        checkEq("sll_31.literal", resultBus, 32'h8000_0000);
        runOp("sll_shamt0", ALU_SLL, 32'h1234_5678, 32'h0000_0020);
        runOp("sra_shamt0", ALU_SRA, 32'h8765_4321, 32'hFFFF_FFE0);

        // Backpressure: result holds while out_ready is low
        @(negedge clk);
        outReady   = 1'b0;
        aluControl = ALU_ADD;
        opA        = 32'd100;
        opB        = 32'd23;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkEq("bp.out_valid", 32'(outValid), 32'd1);
        checkEq("bp.result", resultBus, 32'd123);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkEq("bp.hold_result", resultBus, 32'd123);
            checkEq("bp.hold_in_ready", 32'(inReady), 32'd0);
            checkEq("bp.hold_out_valid", 32'(outValid), 32'd1);
        end
        outReady   = 1'b1;
        aluControl = ALU_XOR;
        opA        = 32'hF0F0_F0F0;
        opB        = 32'h0FF0_0FF0;
        inValid    = 1'b1;
        #1;
        checkEq("bp.release_in_ready", 32'(inReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        refModel(ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, er, ec);
        checkEq("bp.next_out_valid", 32'(outValid), 32'd1);
        checkEq("bp.next_result", resultBus, er);

        // Throughput: one non-shift op per cycle
        @(negedge clk);
        prevOp     = 3'($urandom_range(0, 4));
        prevA      = $urandom;
        prevB      = $urandom;
        aluControl = prevOp;
        opA        = prevA;
        opB        = prevB;
        inValid    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            refModel(prevOp, prevA, prevB, er, ec);
            checkEq("tput.out_valid", 32'(outValid), 32'd1);
            checkEq("tput.result", resultBus, er);
            checkEq("tput.carry", 32'(carryFlag), 32'(ec));
            if (k < 4) begin
                prevOp     = 3'($urandom_range(0, 4));
                prevA      = $urandom;
                prevB      = $urandom;
                aluControl = prevOp;
                opA        = prevA;
                opB        = prevB;
            end else begin
                inValid = 1'b0;
            end
        end

        // Reset pulse during an SLL by 20
        @(negedge clk);
        aluControl = ALU_SLL;
        opA        = 32'h0000_0003;
        opB        = 32'd20;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        checkEq("rstmid.out_valid", 32'(outValid), 32'd0);
        checkEq("rstmid.result", resultBus, 32'd0);
        checkEq("rstmid.carry", 32'(carryFlag), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkEq("rstmid.in_ready", 32'(inReady), 32'd1);
        sawValid = 0;
        repeat (40) begin
            @(negedge clk);
            if (outValid === 1'b1) sawValid++;
        end
        checkEq("rstmid.no_stale_output", sawValid, 32'd0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = $urandom;
            rB  = $urandom;
            if (i % 7 == 3) rA = 32'hFFFF_FFFF;
            if (i % 6 == 2) rB = rA;
            runOp("rand", rOp, rA, rB);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
